// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the read-side FIFO drainer.
package fifo_rd_pkg;

  // Burst sequencing states of the drainer
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } drain_state_e;

  // Output skid buffer depth and the width needed to count 0..BUF_DEPTH
  localparam int BUF_DEPTH = 2;
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/rd_skid_buf.sv
// Small shift-style skid buffer holding {last, data} entries.
// Entry 0 is always the head; a pop shifts the remaining entries down.
// Simultaneous push and pop is legal and keeps the count unchanged.
module rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             push_last,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output logic [W-1:0]     head_data,
  output logic             head_last
);

  logic [CNT_W-1:0] count_reg;
  logic [W:0]       entry_reg [BUF_DEPTH];
  logic             pop_ok;
  logic             push_ok;
  logic [CNT_W-1:0] wr_idx;

  // A pop only counts when something is held; a push is dropped if full and not popping
  assign pop_ok  = pop && (count_reg != '0);
  assign push_ok = push && ((count_reg < CNT_W'(BUF_DEPTH)) || pop_ok);
  // New data lands just behind the surviving entries
  assign wr_idx  = pop_ok ? (count_reg - 1'b1) : count_reg;

  // Occupancy tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Entry storage: shift toward the head on pop, write at the tail on push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        entry_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        if (push_ok && (wr_idx == CNT_W'(i))) begin
          entry_reg[i] <= {push_last, push_data};
        end else if (pop_ok && (i < BUF_DEPTH - 1)) begin
          entry_reg[i] <= entry_reg[(i < BUF_DEPTH - 1) ? i + 1 : i];
        end
      end
    end
  end

  assign count     = count_reg;
  assign head_data = entry_reg[0][W-1:0];
  // The tag of a stale head entry must not leak out once the buffer empties
  assign head_last = entry_reg[0][W] && (count_reg != '0);

endmodule

// File: rtl/async_fifo_rd_drainer.sv
// Read-domain burst drainer: pops a programmed number of words from a
// first-word-fall-through FIFO and re-presents them on a valid/ready stream
// with the final word tagged, plus completion and empty-stall statistics.
// Optional build macro DRAIN_SEQ_CHECK_EN adds an incrementing-sequence
// checker on the popped words; without it seq_err is tied low.
module async_fifo_rd_drainer
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_W      = 11,
  parameter int STALL_W    = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_W-1:0]      words_read,
  output logic [STALL_W-1:0]    empty_stalls,
  output logic                  seq_err
);

  drain_state_e         state_reg;
  logic [LEN_W-1:0]     remaining_reg;
  logic [LEN_W-1:0]     words_read_reg;
  logic [STALL_W-1:0]   stalls_reg;
  logic [CNT_W-1:0]     buf_count;
  logic                 out_fire;
  logic                 start_ok;

  // Pop only when a word is present, words are still owed and the buffer has room
  assign rinc = (state_reg == DRAIN) && !rempty && (remaining_reg != '0) &&
                (buf_count < CNT_W'(BUF_DEPTH));

  assign m_valid  = (buf_count != '0);
  assign out_fire = m_valid && m_ready;
  assign start_ok = (state_reg == IDLE) && start;

  rd_skid_buf #(
    .W (DATA_WIDTH)
  ) u_skid (
    .clk       (rclk),
    .rst       (rrst),
    .push      (rinc),
    .push_data (rdata),
    .push_last (remaining_reg == LEN_W'(1)),
    .pop       (out_fire),
    .count     (buf_count),
    .head_data (m_data),
    .head_last (m_last)
  );

  // Burst sequencing, word accounting and stall statistics
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_reg      <= IDLE;
      remaining_reg  <= '0;
      words_read_reg <= '0;
      stalls_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            words_read_reg <= '0;
            stalls_reg     <= '0;
            if (len != '0) begin
              remaining_reg <= len;
              state_reg     <= DRAIN;
            end else begin
              state_reg     <= DONE;
            end
          end
        end
        DRAIN: begin
          if (rinc) begin
            remaining_reg  <= remaining_reg - 1'b1;
            words_read_reg <= words_read_reg + 1'b1;
            if (remaining_reg == LEN_W'(1)) begin
              state_reg <= FLUSH;
            end
          end
          if (rempty && (remaining_reg != '0) && (stalls_reg != '1)) begin
            stalls_reg <= stalls_reg + 1'b1;
          end
        end
        FLUSH: begin
          if (out_fire && m_last) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy         = (state_reg == DRAIN) || (state_reg == FLUSH);
  assign done         = (state_reg == DONE);
  assign words_read   = words_read_reg;
  assign empty_stalls = stalls_reg;

`ifdef DRAIN_SEQ_CHECK_EN
  logic [DATA_WIDTH-1:0] expect_reg;
  logic                  first_reg;
  logic                  seq_err_reg;

  // First pop of a burst seeds the expected value; later pops must follow it
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      expect_reg  <= '0;
      first_reg   <= 1'b0;
      seq_err_reg <= 1'b0;
    end else if (start_ok) begin
      first_reg   <= 1'b1;
      seq_err_reg <= 1'b0;
    end else if (rinc) begin
      if (first_reg) begin
        expect_reg <= rdata + 1'b1;
        first_reg  <= 1'b0;
      end else begin
        if (rdata != expect_reg) begin
          seq_err_reg <= 1'b1;
        end
        expect_reg <= expect_reg + 1'b1;
      end
    end
  end

  assign seq_err = seq_err_reg;
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_async_fifo_rd_drainer.sv
// Self-checking bench for async_fifo_rd_drainer. A queue-based FIFO model
// feeds the DUT; the monitor checks that the output stream is exactly the
// sequence of words taken from the FIFO, tagged last on the len-th word.
module tb_async_fifo_rd_drainer;

  localparam int DW = 8;
  localparam int LW = 11;
  localparam int SW = 16;
`ifdef DRAIN_SEQ_CHECK_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  logic          rclk = 1'b0;
  logic          rrst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic          rempty = 1'b1;
  logic [DW-1:0] rdata = '0;
  logic          m_ready = 1'b1;
  logic          rinc, m_valid, m_last, busy, done, seq_err;
  logic [DW-1:0] m_data;
  logic [LW-1:0] words_read;
  logic [SW-1:0] empty_stalls;

  async_fifo_rd_drainer #(.DATA_WIDTH(DW), .LEN_W(LW), .STALL_W(SW)) dut (
    .rclk(rclk), .rrst(rrst), .start(start), .len(len), .rempty(rempty),
    .rdata(rdata), .rinc(rinc), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .busy(busy), .done(done),
    .words_read(words_read), .empty_stalls(empty_stalls), .seq_err(seq_err)
  );

  always #5 rclk = ~rclk;

  int n_cmp = 0;
  int n_fail = 0;

  // FIFO model and scoreboard state
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] wr_q[$];
  logic [DW-1:0] popped_q[$];
  bit            pop_now = 1'b0;
  int            pop_cnt = 0, done_cnt = 0, delivered = 0, burst_left = 0, cyc = 0;
  int            last_hs_cyc = 0;
  bit            last_seen = 1'b0, stall_prev = 1'b0, rempty_at_done = 1'b0;
  logic [DW-1:0] held_data = '0;
  int            ready_mode = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge rclk);
      #1;
    end
  endtask

  task automatic push_words(input int n, input int base);
    for (int i = 0; i < n; i++) wr_q.push_back(DW'(base + i));
  endtask

  // FIFO model: apply the pop seen before this edge, accept writer words
  always @(posedge rclk) begin
    if (pop_now && fifo_q.size() > 0) void'(fifo_q.pop_front());
    while (wr_q.size() > 0) fifo_q.push_back(wr_q.pop_front());
    rempty <= (fifo_q.size() == 0);
    rdata  <= (fifo_q.size() != 0) ? fifo_q[0] : '0;
  end

  // Downstream ready generator
  always @(posedge rclk) begin
    #1;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
  end

  // Monitor: sampled mid-cycle, describes what the next edge will do
  always @(negedge rclk) begin
    cyc++;
    pop_now = 1'b0;
    if (rrst) begin
      popped_q.delete();
      burst_left = 0;
      stall_prev = 1'b0;
      last_seen  = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, held_data);
      end
      if (rinc) begin
        check("no_pop_when_empty", rempty, 0);
        popped_q.push_back(rdata);
        pop_cnt++;
        pop_now = 1'b1;
      end
      if (m_valid && m_ready) begin
        check("out_has_word", popped_q.size() > 0, 1);
        if (popped_q.size() > 0) check("out_data", m_data, popped_q.pop_front());
        check("out_last", m_last, burst_left == 1);
        if (burst_left == 1) begin
          last_seen   = 1'b1;
          last_hs_cyc = cyc;
        end
        burst_left--;
        delivered++;
      end
      stall_prev = m_valid && !m_ready;
      held_data  = m_data;
      if (done) begin
        done_cnt++;
        rempty_at_done = rempty;
        if (last_seen) check("done_latency", cyc - last_hs_cyc, 1);
        last_seen = 1'b0;
      end
    end
  end

  task automatic fire(input int n, input bit track);
    start = 1'b1;
    len   = LW'(n);
    if (track) burst_left = n;
    tick();
    start = 1'b0;
    len   = '0;
  endtask

  task automatic finish_burst(input string name, input int d0, input int p0, input int del0,
                              input int n, input int budget, input bit chk_seq);
    for (int c = 0; c < budget && done_cnt == d0; c++) tick();
    check({name, "_done_seen"}, done_cnt != d0, 1);
    tick(3);
    check({name, "_done_once"}, done_cnt - d0, 1);
    check({name, "_pops"}, pop_cnt - p0, n);
    check({name, "_delivered"}, delivered - del0, n);
    check({name, "_words_read"}, words_read, n);
    check({name, "_busy_idle"}, busy, 0);
    if (chk_seq) check({name, "_seq_err"}, seq_err, 0);
  endtask

  task automatic run_burst(input string name, input int n, input int budget, input bit chk_seq);
    int d0, p0, del0;
    d0 = done_cnt; p0 = pop_cnt; del0 = delivered;
    fire(n, 1'b1);
    finish_burst(name, d0, p0, del0, n, budget, chk_seq);
  endtask

  task automatic check_cleared(input string name);
    check(name, {rinc, m_valid, m_last, busy, done, seq_err, m_data, words_read, empty_stalls}, 0);
  endtask

  typedef struct {
    int len;
    int base;
    int ready_mode;
    int exp_words;
  } vec_t;
  vec_t tbl[10];

  initial begin
    int d0, p0, del0;
    tbl[0] = '{len: 4,  base: 0,   ready_mode: 0, exp_words: 4};
    tbl[1] = '{len: 1,  base: 77,  ready_mode: 0, exp_words: 1};
    tbl[2] = '{len: 5,  base: 253, ready_mode: 1, exp_words: 5};
    tbl[3] = '{len: 16, base: 128, ready_mode: 1, exp_words: 16};
    for (int i = 4; i < 10; i++) begin
      tbl[i].len        = $urandom_range(1, 60);
      tbl[i].base       = $urandom_range(0, 255);
      tbl[i].ready_mode = $urandom_range(0, 1);
      tbl[i].exp_words  = tbl[i].len;
    end

    // Reset state
    tick(3);
    check_cleared("reset_outputs");
    rrst = 1'b0;
    tick(2);
    check_cleared("after_reset");

    // Table-driven bursts (entry 0 is the basic 0..3 drain)
    for (int i = 0; i < 10; i++) begin
      push_words(tbl[i].len, tbl[i].base);
      tick();
      ready_mode = tbl[i].ready_mode;
      run_burst($sformatf("vec%0d", i), tbl[i].exp_words, tbl[i].len * 30 + 50, 1'b1);
      $display("vec%0d len=%0d base=%0d ready_mode=%0d words_read=%0d", i,
               tbl[i].len, tbl[i].base, tbl[i].ready_mode, words_read);
    end
    ready_mode = 0;
    tick();

    // Full 1024-word drain
    push_words(1024, 0);
    tick();
    run_burst("full", 1024, 3000, 1'b1);
    check("full_rempty_at_done", rempty_at_done, 1);
    $display("full drain words_read=%0d", words_read);

    // Backpressure: two pops fill the buffer, then everything waits
    push_words(8, 10);
    tick();
    ready_mode = 2;
    tick();
    d0 = done_cnt; p0 = pop_cnt; del0 = delivered;
    fire(8, 1'b1);
    tick(10);
    check("bp_pops_during_stall", pop_cnt - p0, 2);
    check("bp_valid_held", m_valid, 1);
    ready_mode = 0;
    finish_burst("bp", d0, p0, del0, 8, 200, 1'b1);
    $display("backpressure burst words_read=%0d", words_read);

    // Empty stall: one word now, two more after 20 cycles
    push_words(1, 100);
    tick();
    d0 = done_cnt; p0 = pop_cnt; del0 = delivered;
    fire(3, 1'b1);
    tick(20);
    check("estall_busy_waiting", busy, 1);
    push_words(2, 101);
    finish_burst("estall", d0, p0, del0, 3, 100, 1'b1);
    check("estall_count_near_20", (empty_stalls >= 18) && (empty_stalls <= 22), 1);
    $display("empty stall burst empty_stalls=%0d", empty_stalls);

    // len=0: done without any pop
    run_burst("len0", 0, 20, 1'b1);
    $display("len0 burst done_cnt=%0d", done_cnt);

    // Start while busy is ignored
    push_words(6, 40);
    tick();
    d0 = done_cnt; p0 = pop_cnt; del0 = delivered;
    fire(4, 1'b1);
    tick(2);
    fire(2, 1'b0);
    finish_burst("busy_start", d0, p0, del0, 4, 100, 1'b1);
    check("busy_start_fifo_left", fifo_q.size(), 2);
    run_burst("busy_rest", 2, 100, 1'b1);
    $display("start-while-busy burst words_read=%0d", words_read);

    // Reset mid-burst with a full buffer
    push_words(6, 200);
    tick();
    ready_mode = 2;
    tick();
    fire(6, 1'b1);
    tick(5);
    check("rst_mid_busy", busy, 1);
    rrst = 1'b1;
    tick();
    check_cleared("rst_mid_cleared");
    rrst = 1'b0;
    ready_mode = 0;
    tick(2);
    check_cleared("rst_mid_idle");
    check("rst_fifo_left", fifo_q.size(), 4);
    run_burst("post_rst", 4, 100, 1'b1);
    $display("post-reset burst words_read=%0d", words_read);

    // Sequence checker: 5,6,9 trips it at the third pop
    wr_q.push_back(8'd5);
    wr_q.push_back(8'd6);
    wr_q.push_back(8'd9);
    tick();
    d0 = done_cnt; p0 = pop_cnt; del0 = delivered;
    fire(3, 1'b1);
    tick(2);
    check("seq_two_pops", pop_cnt - p0, 2);
    check("seq_before_9", seq_err, 0);
    tick();
    check("seq_after_9", seq_err, SEQ_EN);
    finish_burst("seq", d0, p0, del0, 3, 50, 1'b0);
    check("seq_sticky", seq_err, SEQ_EN);
    run_burst("seq_clear", 0, 20, 1'b1);
    $display("sequence burst seq_err_expected=%0d seq_err=%0d", SEQ_EN, seq_err);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
